// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency single-port memory between instruction fetch and load/store.
// Optional memory-wait watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [3:0]        m_be_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              busy_o,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {IDLE, MEM_I, MEM_D, RESP} state_e;

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              sel_d_q, sel_d_d;
  logic              m_we_q, m_we_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] resp_data;
  logic              timed_out;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    sel_d_d    = sel_d_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    timed_out  = 1'b0;
    resp_data  = m_rdata_i;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d     = wait_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d = '0;
`endif
        // Data wins ties until it has starved a waiting fetch MAX_D_STREAK times.
        if (d_req_i && !(if_req_i && streak_q == SW'(MAX_D_STREAK))) begin
          state_d   = MEM_D;
          sel_d_d   = 1'b1;
          m_we_d    = d_we_i;
          m_be_d    = d_we_i ? d_be_i : 4'hF;
          m_addr_d  = d_addr_i;
          m_wdata_d = d_wdata_i;
          if (!if_req_i)
            streak_d = '0;
          else if (streak_q != SW'(MAX_D_STREAK))
            streak_d = streak_q + 1'b1;
        end else if (if_req_i) begin
          state_d   = MEM_I;
          sel_d_d   = 1'b0;
          m_we_d    = 1'b0;
          m_be_d    = 4'hF;
          m_addr_d  = if_addr_i;
          m_wdata_d = '0;
          streak_d  = '0;
        end else begin
          streak_d  = '0;
        end
      end
      MEM_I, MEM_D: begin
`ifdef MEM_ARB_TIMEOUT_EN
        if (!m_ack_i) begin
          if (wait_q == WW'(TIMEOUT - 1)) timed_out = 1'b1;
          else                            wait_d    = wait_q + 1'b1;
        end
`endif
        if (timed_out) resp_data = DATA_W'(32'hDEADBEEF);
        if (m_ack_i || timed_out) begin
          state_d = RESP;
          if (state_q == MEM_I) if_rdata_d = resp_data;
          else                  d_rdata_d  = resp_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      sel_d_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      sel_d_q    <= sel_d_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_q | timed_out;
    end
  end
  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  // m_req comes straight from the state register so reset drops it immediately.
  assign m_req_o    = (state_q == MEM_I) || (state_q == MEM_D);
  assign busy_o     = (state_q != IDLE);
  assign if_gnt_o   = (state_q == RESP) && !sel_d_q;
  assign d_gnt_o    = (state_q == RESP) &&  sel_d_q;
  assign m_we_o     = m_we_q;
  assign m_be_o     = m_be_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign if_rdata_o = if_rdata_q;
  assign d_rdata_o  = d_rdata_q;

endmodule
